// File: rtl/cp0_exc_unit_if.sv
// CP0 access bundle between the writeback stage (master) and the CP0 unit (slave).
// Carries MTC0/MFC0, exception/ERET commit and the status outputs back to the pipeline.
`timescale 1ns/1ps
interface cp0_exc_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             we;
   logic [4:0]       waddr;
   logic [WIDTH-1:0] wdata;
   logic [4:0]       raddr;
   logic [WIDTH-1:0] rdata;
   logic [5:0]       hw_int;
   logic             exc_valid;
   logic [4:0]       exc_code;
   logic             exc_bd;
   logic [WIDTH-1:0] exc_pc;
   logic             exc_badv_valid;
   logic [WIDTH-1:0] exc_badvaddr;
   logic             eret;
   logic [WIDTH-1:0] epc_out;
   logic [WIDTH-1:0] exc_target;
   logic             int_pending;
   logic             kernel_mode;
   logic             timer_int;

   modport master (
      output we, waddr, wdata, raddr, hw_int, exc_valid, exc_code, exc_bd,
             exc_pc, exc_badv_valid, exc_badvaddr, eret,
      input  rdata, epc_out, exc_target, int_pending, kernel_mode, timer_int
   );

   modport slave (
      input  we, waddr, wdata, raddr, hw_int, exc_valid, exc_code, exc_bd,
             exc_pc, exc_badv_valid, exc_badvaddr, eret,
      output rdata, epc_out, exc_target, int_pending, kernel_mode, timer_int
   );
endinterface

// File: rtl/cp0_exc_unit.sv
// MIPS CP0 registers, exception/ERET commit, divided Count/Compare timer and interrupt masking.
// All state updates in one cycle, MFC0 read is combinational; no backpressure (one commit per cycle).
`timescale 1ns/1ps
module cp0_exc_unit #(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      COUNT_DIV  = 2,
   parameter logic [WIDTH-1:0] PRID_VALUE = 32'h0000_4220,
   parameter logic [WIDTH-1:0] CONFIG_RST = 32'h0000_8000,
   parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input logic           clk,
   input logic           rst,
   cp0_exc_unit_if.slave cp0_if
);

   localparam logic [4:0] REG_BADV    = 5'd8;
   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;
   localparam logic [4:0] REG_CONFIG  = 5'd16;

   localparam int unsigned     DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   logic [WIDTH-1:0] badv_q, badv_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] compare_q, compare_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [WIDTH-1:0] config_q, config_d;
   logic [7:0]       im_q, im_d;
   logic             exl_q, exl_d;
   logic             ie_q, ie_d;
   logic [5:0]       hw_ip_q, hw_ip_d;
   logic [1:0]       sw_ip_q, sw_ip_d;
   logic             bd_q, bd_d;
   logic             ti_q, ti_d;
   logic [4:0]       exc_code_q, exc_code_d;
   logic [DIV_W-1:0] div_q, div_d;

   logic             wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_config;
   logic             tick;
   logic [WIDTH-1:0] count_inc;
   logic [7:0]       ip_full;
   logic [31:0]      status_word, cause_word;
   logic [WIDTH-1:0] rdata;

   assign wr_count   = cp0_if.we && (cp0_if.waddr == REG_COUNT);
   assign wr_compare = cp0_if.we && (cp0_if.waddr == REG_COMPARE);
   assign wr_status  = cp0_if.we && (cp0_if.waddr == REG_STATUS);
   assign wr_cause   = cp0_if.we && (cp0_if.waddr == REG_CAUSE);
   assign wr_epc     = cp0_if.we && (cp0_if.waddr == REG_EPC);
   assign wr_config  = cp0_if.we && (cp0_if.waddr == REG_CONFIG);

   assign tick      = (div_q == DIV_LAST);
   assign count_inc = count_q + WIDTH'(1);
   assign hw_ip_d   = cp0_if.hw_int;

   // Timer: a Count load restarts the divider and never raises TI; a Compare write always clears TI.
   always_comb begin
      div_d     = tick ? '0 : div_q + DIV_W'(1);
      count_d   = tick ? count_inc : count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (wr_count) begin
         div_d   = '0;
         count_d = cp0_if.wdata;
      end else if (tick && (count_inc == compare_q)) begin
         ti_d = 1'b1;
      end
      if (wr_compare) begin
         compare_d = cp0_if.wdata;
         ti_d      = 1'b0;
      end
   end

   // Later assignments win: MTC0, then ERET, then exception on the fields they share.
   always_comb begin
      im_d       = im_q;
      ie_d       = ie_q;
      exl_d      = exl_q;
      sw_ip_d    = sw_ip_q;
      bd_d       = bd_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      badv_d     = badv_q;
      config_d   = config_q;
      if (wr_status) begin
         im_d  = cp0_if.wdata[15:8];
         exl_d = cp0_if.wdata[1];
         ie_d  = cp0_if.wdata[0];
      end
      if (wr_cause) begin
         sw_ip_d = cp0_if.wdata[9:8];
      end
      if (wr_epc) begin
         epc_d = cp0_if.wdata;
      end
      if (wr_config) begin
         config_d = cp0_if.wdata;
      end
      if (cp0_if.eret) begin
         exl_d = 1'b0;
      end
      if (cp0_if.exc_valid) begin
         exl_d      = 1'b1;
         exc_code_d = cp0_if.exc_code;
         // Nested exceptions keep the original return address and BD flag.
         if (!exl_q) begin
            epc_d = cp0_if.exc_bd ? cp0_if.exc_pc - WIDTH'(4) : cp0_if.exc_pc;
            bd_d  = cp0_if.exc_bd;
         end
         if (cp0_if.exc_badv_valid) begin
            badv_d = cp0_if.exc_badvaddr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         badv_q     <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         epc_q      <= '0;
         config_q   <= CONFIG_RST;
         im_q       <= '0;
         exl_q      <= 1'b1;
         ie_q       <= 1'b0;
         hw_ip_q    <= '0;
         sw_ip_q    <= '0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         exc_code_q <= '0;
         div_q      <= '0;
      end else begin
         badv_q     <= badv_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         config_q   <= config_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         hw_ip_q    <= hw_ip_d;
         sw_ip_q    <= sw_ip_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         exc_code_q <= exc_code_d;
         div_q      <= div_d;
      end
   end

   // IP7 is shared between hardware line 5 and the timer.
   assign ip_full     = {hw_ip_q[5] | ti_q, hw_ip_q[4:0], sw_ip_q};
   assign status_word = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
   assign cause_word  = {bd_q, ti_q, 14'd0, ip_full, 1'b0, exc_code_q, 2'b00};

   always_comb begin
      rdata = '0;
      case (cp0_if.raddr)
         REG_BADV:    rdata = badv_q;
         REG_COUNT:   rdata = count_q;
         REG_COMPARE: rdata = compare_q;
         REG_STATUS:  rdata = WIDTH'(status_word);
         REG_CAUSE:   rdata = WIDTH'(cause_word);
         REG_EPC:     rdata = epc_q;
         REG_PRID:    rdata = PRID_VALUE;
         REG_CONFIG:  rdata = config_q;
         default:     rdata = '0;
      endcase
   end

   assign cp0_if.rdata       = rdata;
   assign cp0_if.epc_out     = epc_q;
   assign cp0_if.exc_target  = EXC_VECTOR;
   assign cp0_if.int_pending = ie_q & ~exl_q & (|(ip_full & im_q));
   assign cp0_if.kernel_mode = exl_q;
   assign cp0_if.timer_int   = ti_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: word-level register model checked every cycle,
// plus literal expectations at the interesting points.
`timescale 1ns/1ps
module tb_cp0_exc_unit;
   localparam int DIV = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cp0_exc_unit_if #(.WIDTH(32)) bus ();

   cp0_exc_unit #(
      .WIDTH(32), .COUNT_DIV(DIV), .PRID_VALUE(32'h0000_4220),
      .CONFIG_RST(32'h0000_8000), .EXC_VECTOR(32'hBFC0_0380)
   ) dut (
      .clk(clk), .rst(rst), .cp0_if(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   // Model: whole 32-bit register words with write masks; Count derived from elapsed edges.
   logic        m_ok = 1'b0;
   longint      tcyc = 0;
   longint      m_load_t = 0;
   logic [31:0] m_base, m_compare, m_status, m_cause, m_epc, m_badv, m_config;
   logic        m_ti;

   function automatic logic [31:0] m_count_at(input longint t);
      return m_base + 32'((t - m_load_t) / DIV);
   endfunction

   function automatic logic [31:0] m_cause_rd();
      return m_cause | (m_ti ? 32'h4000_8000 : 32'h0);
   endfunction

   function automatic logic m_int();
      logic [31:0] c;
      c = m_cause_rd();
      return m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'h0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_badv;
         5'd9:    return m_count_at(tcyc);
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause_rd();
         5'd14:   return m_epc;
         5'd15:   return 32'h0000_4220;
         5'd16:   return m_config;
         default: return 32'h0;
      endcase
   endfunction

   initial begin : model_p
      longint      nt;
      logic        ticked, wr_cnt, wr_cmp, exl_old;
      logic [31:0] new_cnt;
      forever begin
         @(posedge clk);
         nt = tcyc + 1;
         if (rst) begin
            m_base = 0; m_load_t = nt; m_compare = 0; m_status = 32'h0040_0002;
            m_cause = 0; m_epc = 0; m_badv = 0; m_config = 32'h0000_8000; m_ti = 1'b0;
            m_ok = 1'b1;
         end else begin
            wr_cnt  = bus.we && (bus.waddr == 5'd9);
            wr_cmp  = bus.we && (bus.waddr == 5'd11);
            ticked  = ((nt - m_load_t) % DIV) == 0;
            new_cnt = m_count_at(nt);
            exl_old = m_status[1];
            if (wr_cmp) m_ti = 1'b0;
            else if (!wr_cnt && ticked && new_cnt == m_compare) m_ti = 1'b1;
            if (wr_cmp) m_compare = bus.wdata;
            if (wr_cnt) begin
               m_base = bus.wdata;
               m_load_t = nt;
            end
            if (bus.we && bus.waddr == 5'd12) m_status = (m_status & ~32'h0000_FF03) | (bus.wdata & 32'h0000_FF03);
            if (bus.we && bus.waddr == 5'd13) m_cause = (m_cause & ~32'h0000_0300) | (bus.wdata & 32'h0000_0300);
            if (bus.we && bus.waddr == 5'd14) m_epc = bus.wdata;
            if (bus.we && bus.waddr == 5'd16) m_config = bus.wdata;
            m_cause[15:10] = bus.hw_int;
            if (bus.eret) m_status[1] = 1'b0;
            if (bus.exc_valid) begin
               m_status[1] = 1'b1;
               m_cause[6:2] = bus.exc_code;
               if (!exl_old) begin
                  m_epc = bus.exc_pc - (bus.exc_bd ? 32'd4 : 32'd0);
                  m_cause[31] = bus.exc_bd;
               end
               if (bus.exc_badv_valid) m_badv = bus.exc_badvaddr;
            end
         end
         tcyc = nt;
      end
   end

   initial begin : compare_p
      forever begin
         @(negedge clk);
         if (m_ok) begin
            chk("rdata", bus.rdata, m_read(bus.raddr));
            chk("epc_out", bus.epc_out, m_epc);
            chk("exc_target", bus.exc_target, 32'hBFC0_0380);
            chk1("int_pending", bus.int_pending, m_int());
            chk1("kernel_mode", bus.kernel_mode, m_status[1]);
            chk1("timer_int", bus.timer_int, m_ti);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
      cyc();
      bus.we = 1'b0;
   endtask

   task automatic lit(input string name, input logic [4:0] a, input logic [31:0] want);
      bus.raddr = a;
      #1;
      chk(name, bus.rdata, want);
   endtask

   initial begin : stim_p
      logic [4:0] sweep [10];
      sweep = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd31};
      bus.we = 0; bus.waddr = 0; bus.wdata = 0; bus.raddr = 0; bus.hw_int = 0;
      bus.exc_valid = 0; bus.exc_code = 0; bus.exc_bd = 0; bus.exc_pc = 0;
      bus.exc_badv_valid = 0; bus.exc_badvaddr = 0; bus.eret = 0;
      rst = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;

      lit("rst_status", 5'd12, 32'h0040_0002);
      lit("rst_cause", 5'd13, 32'h0);
      lit("rst_prid", 5'd15, 32'h0000_4220);
      lit("rst_config", 5'd16, 32'h0000_8000);
      chk1("rst_kernel", bus.kernel_mode, 1'b1);
      chk1("rst_int", bus.int_pending, 1'b0);

      // Same-cycle read returns the pre-write value; write masks.
      bus.raddr = 5'd12; bus.we = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'hFFFF_FFFF;
      #1 chk("no_bypass", bus.rdata, 32'h0040_0002);
      cyc();
      bus.we = 1'b0;
      lit("status_mask", 5'd12, 32'h0040_FF03);
      mtc0(5'd13, 32'hFFFF_FFFF);
      lit("cause_mask", 5'd13, 32'h0000_0300);
      mtc0(5'd12, 32'h0000_0101);
      chk1("sw_int", bus.int_pending, 1'b1);
      mtc0(5'd13, 32'h0);
      chk1("sw_int_clr", bus.int_pending, 1'b0);
      mtc0(5'd8, 32'hDEAD_0000);
      mtc0(5'd3, 32'hBEEF_0000);
      mtc0(5'd15, 32'h0);
      lit("badv_ro", 5'd8, 32'h0);
      lit("unimpl", 5'd3, 32'h0);
      lit("prid_ro", 5'd15, 32'h0000_4220);
      mtc0(5'd16, 32'h1234_5678);
      lit("config_wr", 5'd16, 32'h1234_5678);

      // Timer: Count 0 -> 5 takes ten edges at DIV=2.
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      repeat (9) cyc();
      lit("cnt_4", 5'd9, 32'd4);
      chk1("ti_before", bus.timer_int, 1'b0);
      cyc();
      lit("cnt_5", 5'd9, 32'd5);
      chk1("ti_set", bus.timer_int, 1'b1);
      lit("cause_ti", 5'd13, 32'h4000_8000);
      mtc0(5'd11, 32'd9);
      chk1("ti_clr", bus.timer_int, 1'b0);
      mtc0(5'd11, 32'hFFFF_0000);

      // Hardware interrupt through IP2.
      mtc0(5'd12, 32'h0000_0401);
      lit("status_401", 5'd12, 32'h0040_0401);
      bus.hw_int = 6'b000001;
      #1 chk1("int_latency", bus.int_pending, 1'b0);
      cyc();
      chk1("hw_int", bus.int_pending, 1'b1);
      lit("cause_ip2", 5'd13, 32'h0000_0400);
      mtc0(5'd12, 32'h0000_0403);
      chk1("exl_masks", bus.int_pending, 1'b0);
      bus.hw_int = 6'b0;

      // Exceptions.
      bus.eret = 1'b1; cyc(); bus.eret = 1'b0;
      chk1("eret_user", bus.kernel_mode, 1'b0);
      bus.exc_valid = 1; bus.exc_bd = 1; bus.exc_pc = 32'h8000_1004; bus.exc_code = 5'd4;
      bus.exc_badv_valid = 1; bus.exc_badvaddr = 32'h1235;
      cyc();
      bus.exc_valid = 0; bus.exc_badv_valid = 0;
      chk("exc_epc", bus.epc_out, 32'h8000_1000);
      lit("exc_cause", 5'd13, 32'h8000_0010);
      lit("exc_badv", 5'd8, 32'h1235);
      chk1("exc_kernel", bus.kernel_mode, 1'b1);
      bus.exc_valid = 1; bus.exc_bd = 0; bus.exc_pc = 32'h2000; bus.exc_code = 5'd5;
      cyc();
      bus.exc_valid = 0;
      chk("nest_epc", bus.epc_out, 32'h8000_1000);
      lit("nest_cause", 5'd13, 32'h8000_0014);
      lit("nest_badv", 5'd8, 32'h1235);

      bus.eret = 1'b1; cyc(); bus.eret = 1'b0;
      bus.exc_valid = 1; bus.exc_pc = 32'h3000; bus.exc_code = 5'd0; bus.eret = 1;
      bus.we = 1; bus.waddr = 5'd12; bus.wdata = 32'h0;
      cyc();
      bus.exc_valid = 0; bus.eret = 0; bus.we = 0;
      lit("prio_status", 5'd12, 32'h0040_0002);
      chk("prio_epc", bus.epc_out, 32'h3000);
      lit("prio_cause", 5'd13, 32'h0);

      // Count load never raises TI; wrap raises it.
      mtc0(5'd11, 32'd7);
      mtc0(5'd9, 32'd7);
      chk1("cnt_wr_no_ti", bus.timer_int, 1'b0);
      lit("cnt_load", 5'd9, 32'd7);
      mtc0(5'd11, 32'd0);
      mtc0(5'd9, 32'hFFFF_FFFF);
      lit("cnt_max", 5'd9, 32'hFFFF_FFFF);
      cyc(); cyc();
      lit("cnt_wrap", 5'd9, 32'd0);
      chk1("ti_wrap", bus.timer_int, 1'b1);

      // Reset overrides a simultaneous exception.
      bus.exc_valid = 1; bus.exc_pc = 32'h4000; rst = 1'b1;
      cyc();
      rst = 1'b0; bus.exc_valid = 0;
      lit("rst2_status", 5'd12, 32'h0040_0002);
      chk("rst2_epc", bus.epc_out, 32'h0);
      chk1("rst2_ti", bus.timer_int, 1'b0);

      for (int i = 0; i < 10; i++) begin
         bus.raddr = sweep[i];
         cyc();
      end
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
